reset_sequencer: RTL

- Sits directly downstream of the watchdog and consumes its reset pulse.
- Merges that pulse with the debounced external reset pin and produces stretched, staged system resets: peripherals are released first, the CPU a fixed delay later.
- External-pin resets first request a graceful bus quiesce, bounded by a timeout. Watchdog/trap resets are immediate.
- Reports the cause of the most recent reset.

---
 rtl/reset_seq_pkg.sv | 28 ++
 rtl/reset_debounce.sv | 56 +++++
 rtl/reset_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer and its pin debouncer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    QUIESCE    = 2'd1,
    ASSERT     = 2'd2,
    PERIPH_REL = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_POR = 2'd0,
    CAUSE_WDT = 2'd1,
    CAUSE_EXT = 2'd2
  } cause_t;

  function automatic int max_of3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // One spare bit so a counter loaded with its maximum value never wraps.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/reset_debounce.sv
// Two-flop synchroniser and level debouncer for the external reset pin.
// The debounced level only changes after DEBOUNCE_CYCLES consecutive
// synchronised samples disagree with it; press pulses for one cycle on a
// debounced high-to-low change.
module reset_debounce
  import reset_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 256
) (
  input  logic clk,
  input  logic power_on_reset_n,
  input  logic pin_n,
  output logic level,
  output logic press
);

  localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);

  logic            sync_1;
  logic            sync_2;
  logic [DB_W-1:0] db_cnt;

  // Bring the asynchronous pin into the clk domain; idle level is released (1).
  always_ff @(posedge clk) begin
    if (!power_on_reset_n) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= pin_n;
      sync_2 <= sync_1;
    end
  end

  // Count consecutive disagreeing samples; flip the level on the last one.
  always_ff @(posedge clk) begin
    if (!power_on_reset_n) begin
      level  <= 1'b1;
      db_cnt <= '0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync_2 == level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        level  <= sync_2;
        db_cnt <= '0;
        press  <= ~sync_2;
      end else begin
        db_cnt <= db_cnt + DB_ONE;
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Staged system reset generator: merges the watchdog pulse with the
// debounced external pin, stretches the result and releases peripherals
// ahead of the CPU. Pin resets first ask the bus to quiesce.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// RUN        | normal operation, all resets released
// QUIESCE    | pin press seen, waiting for quiesce_ack or timeout
// ASSERT     | periph and cpu reset held, stretch counter running
// PERIPH_REL | peripherals released, cpu still held for PERIPH_TO_CPU
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int STRETCH_CYCLES  = 16,
  parameter int PERIPH_TO_CPU   = 4,
  parameter int DEBOUNCE_CYCLES = 256,
  parameter int QUIESCE_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       power_on_reset_n,
  input  logic       wdt_reset,
  input  logic       ext_reset_n_pin,
  input  logic       quiesce_ack,
  output logic       quiesce_req,
  output logic       periph_reset,
  output logic       cpu_reset,
  output logic       reset_busy,
  output logic [1:0] last_cause
);

  localparam int CNT_W = cnt_width(max_of3(STRETCH_CYCLES, PERIPH_TO_CPU, QUIESCE_TIMEOUT));
  localparam logic [CNT_W-1:0] STRETCH_RELOAD = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] P2C_RELOAD     = CNT_W'(PERIPH_TO_CPU - 1);
  localparam logic [CNT_W-1:0] QUIESCE_RELOAD = CNT_W'(QUIESCE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE        = CNT_W'(1);

  state_t             state, state_nxt;
  cause_t             cause, cause_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               pin_level;
  logic               pin_press;

  reset_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk              (clk),
    .power_on_reset_n (power_on_reset_n),
    .pin_n            (ext_reset_n_pin),
    .level            (pin_level),
    .press            (pin_press)
  );

  // State, shared counter, cause and outputs all registered from next-state.
  always_ff @(posedge clk) begin
    if (!power_on_reset_n) begin
      state        <= ASSERT;
      cnt          <= STRETCH_RELOAD;
      cause        <= CAUSE_POR;
      periph_reset <= 1'b1;
      cpu_reset    <= 1'b1;
      quiesce_req  <= 1'b0;
      reset_busy   <= 1'b1;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      cause        <= cause_nxt;
      periph_reset <= (state_nxt == ASSERT);
      cpu_reset    <= (state_nxt == ASSERT) || (state_nxt == PERIPH_REL);
      quiesce_req  <= (state_nxt == QUIESCE);
      reset_busy   <= (state_nxt != RUN);
    end
  end

  assign last_cause = cause;

  // Next-state, counter and cause; watchdog always wins over the pin path.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cause_nxt = cause;
    case (state)
      RUN: begin
        if (wdt_reset) begin
          state_nxt = ASSERT;
          cnt_nxt   = STRETCH_RELOAD;
          cause_nxt = CAUSE_WDT;
        end else if (pin_press) begin
          state_nxt = QUIESCE;
          cnt_nxt   = QUIESCE_RELOAD;
        end
      end
      QUIESCE: begin
        if (wdt_reset) begin
          state_nxt = ASSERT;
          cnt_nxt   = STRETCH_RELOAD;
          cause_nxt = CAUSE_WDT;
        end else if (quiesce_ack || (cnt == '0)) begin
          state_nxt = ASSERT;
          cnt_nxt   = STRETCH_RELOAD;
          cause_nxt = CAUSE_EXT;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      ASSERT: begin
        if (wdt_reset) begin
          cnt_nxt   = STRETCH_RELOAD;
          cause_nxt = CAUSE_WDT;
        end else if (!pin_level) begin
          // Pin still held: keep the stretch parked at its full length.
          cnt_nxt = STRETCH_RELOAD;
        end else if (cnt == '0) begin
          state_nxt = PERIPH_REL;
          cnt_nxt   = P2C_RELOAD;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      PERIPH_REL: begin
        if (wdt_reset) begin
          state_nxt = ASSERT;
          cnt_nxt   = STRETCH_RELOAD;
          cause_nxt = CAUSE_WDT;
        end else if (cnt == '0) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: begin
        state_nxt = ASSERT;
        cnt_nxt   = STRETCH_RELOAD;
      end
    endcase
  end

endmodule
